// File: rtl/vga_draw_pkg.sv
// Shared definitions for the VGA draw scheduler: FSM state encoding,
// screen geometry and default coordinate/colour widths.
package vga_draw_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_DRAW  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam int unsigned SCREEN_W    = 160;
   localparam int unsigned SCREEN_H    = 120;
   localparam int unsigned NUM_REQ_DEF = 4;
   localparam int unsigned X_W_DEF     = 8;
   localparam int unsigned Y_W_DEF     = 7;
   localparam int unsigned C_W_DEF     = 9;

endpackage

// File: rtl/vga_draw_scheduler_if.sv
// Bundle between the draw engines / game FSM and the draw scheduler.
//  master : engine side (requests, done, pixel stream) and VGA consumer
//  slave  : scheduler (run enables, completion pulses, VGA plot port, busy)
interface vga_draw_scheduler_if
   import vga_draw_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned X_W     = X_W_DEF,
   parameter int unsigned Y_W     = Y_W_DEF,
   parameter int unsigned C_W     = C_W_DEF
);
   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ-1:0]     eng_done;
   logic [NUM_REQ-1:0]     eng_valid;
   logic [NUM_REQ*X_W-1:0] eng_x;
   logic [NUM_REQ*Y_W-1:0] eng_y;
   logic [NUM_REQ*C_W-1:0] eng_colour;
   logic [NUM_REQ-1:0]     eng_run_n;
   logic [NUM_REQ-1:0]     cmpl;
   logic [X_W-1:0]         vga_x;
   logic [Y_W-1:0]         vga_y;
   logic [C_W-1:0]         vga_colour;
   logic                   vga_plot;
   logic                   busy;

   modport master (
      output req, eng_done, eng_valid, eng_x, eng_y, eng_colour,
      input  eng_run_n, cmpl, vga_x, vga_y, vga_colour, vga_plot, busy
   );

   modport slave (
      input  req, eng_done, eng_valid, eng_x, eng_y, eng_colour,
      output eng_run_n, cmpl, vga_x, vga_y, vga_colour, vga_plot, busy
   );
endinterface

// File: rtl/draw_req_arbiter.sv
// Combinational requester pick: first set req bit found searching upward
// from index start, wrapping at NUM_REQ. start=0 gives fixed priority.
//  req    : request vector
//  start  : first index to search
//  pick_c : winning index (valid when any_c)
//  any_c  : at least one request set
module draw_req_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned GW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GW-1:0]      start,
   output logic [GW-1:0]      pick_c,
   output logic               any_c
);

   // Outer loop walks search order, inner loop maps the rotated index to a constant bit.
   always_comb begin
      int unsigned idx;
      pick_c = '0;
      any_c  = 1'b0;
      idx    = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = 32'(start) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!any_c && (j == idx) && req[j]) begin
               any_c  = 1'b1;
               pick_c = GW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Shares the single VGA plot port between NUM_REQ draw engines. One engine at
// a time is released from reset, its pixel stream is forwarded to the VGA
// adapter with one cycle of latency, and a completion pulse is returned on
// the rising edge of its done flag.
//  clk, resetn : clock, async active-low reset
//  bus (slave) : req/eng_* in; eng_run_n, cmpl, vga_x/y/colour, vga_plot, busy out
// Build option: DRAW_SCHED_RR_EN selects round-robin arbitration
// (default fixed priority, index 0 highest).
module vga_draw_scheduler
   import vga_draw_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned X_W     = X_W_DEF,
   parameter int unsigned Y_W     = Y_W_DEF,
   parameter int unsigned C_W     = C_W_DEF
) (
   input  logic                 clk,
   input  logic                 resetn,
   vga_draw_scheduler_if.slave  bus
);

   localparam int unsigned GW = $clog2(NUM_REQ);

   state_t               state, state_next;
   logic [GW-1:0]        g, g_next, start, pick_c;
   logic                 any_c;
   logic                 sel_valid, sel_done;
   logic [X_W-1:0]       sel_x;
   logic [Y_W-1:0]       sel_y;
   logic [C_W-1:0]       sel_colour;
   logic                 done_prev, done_prev_d;
   logic [NUM_REQ-1:0]   run_n_q, run_n_d, cmpl_q, cmpl_d;
   logic [X_W-1:0]       x_q, x_d;
   logic [Y_W-1:0]       y_q, y_d;
   logic [C_W-1:0]       colour_q, colour_d;
   logic                 plot_q, plot_d, busy_q, busy_d;

`ifdef DRAW_SCHED_RR_EN
   // Last served engine; search resumes one past it.
   logic [GW-1:0] last_g;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)               last_g <= GW'(NUM_REQ - 1);
      else if (state == S_DRAIN) last_g <= g;
   end
   assign start = (last_g == GW'(NUM_REQ - 1)) ? '0 : last_g + GW'(1);
`else
   assign start = '0;
`endif

   draw_req_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_arb (
      .req    (bus.req),
      .start  (start),
      .pick_c (pick_c),
      .any_c  (any_c)
   );

   // Granted engine's pixel stream and done flag.
   always_comb begin
      sel_valid  = 1'b0;
      sel_done   = 1'b0;
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (g == GW'(i)) begin
            sel_valid  = bus.eng_valid[i];
            sel_done   = bus.eng_done[i];
            sel_x      = bus.eng_x[i*X_W +: X_W];
            sel_y      = bus.eng_y[i*Y_W +: Y_W];
            sel_colour = bus.eng_colour[i*C_W +: C_W];
         end
      end
   end

   // State and grant register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         g     <= '0;
      end else begin
         state <= state_next;
         g     <= g_next;
      end
   end

   // Next state; grant is only re-evaluated in IDLE.
   always_comb begin
      state_next = state;
      g_next     = g;
      case (state)
         S_IDLE:  if (any_c) begin
                     state_next = S_ARM;
                     g_next     = pick_c;
                  end
         S_ARM:   state_next = S_DRAW;
         S_DRAW:  if (sel_done && !done_prev) state_next = S_DRAIN;
         S_DRAIN: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      run_n_d  = '1;
      cmpl_d   = '0;
      busy_d   = (state_next != S_IDLE);
      plot_d   = 1'b0;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      // Done is tracked from ARM so a stale level is never taken as a rising edge.
      done_prev_d = 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (g_next == GW'(i)) begin
            run_n_d[i] = !((state_next == S_ARM) || (state_next == S_DRAW));
            cmpl_d[i]  = (state_next == S_DRAIN);
         end
      end
      if ((state == S_ARM) || (state == S_DRAW)) done_prev_d = sel_done;
      if (state == S_DRAW) begin
         plot_d = sel_valid;
         if (sel_valid) begin
            x_d      = sel_x;
            y_d      = sel_y;
            colour_d = sel_colour;
         end
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         run_n_q   <= '1;
         cmpl_q    <= '0;
         plot_q    <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         colour_q  <= '0;
         busy_q    <= 1'b0;
         done_prev <= 1'b1;
      end else begin
         run_n_q   <= run_n_d;
         cmpl_q    <= cmpl_d;
         plot_q    <= plot_d;
         x_q       <= x_d;
         y_q       <= y_d;
         colour_q  <= colour_d;
         busy_q    <= busy_d;
         done_prev <= done_prev_d;
      end
   end

   assign bus.eng_run_n  = run_n_q;
   assign bus.cmpl       = cmpl_q;
   assign bus.vga_plot   = plot_q;
   assign bus.vga_x      = x_q;
   assign bus.vga_y      = y_q;
   assign bus.vga_colour = colour_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Self-checking bench for vga_draw_scheduler. Engine behaviour is modelled by
// tasks; every pixel driven by the granted engine and every expected
// completion are queued and compared as the scheduler emits them.
// Honours DRAW_SCHED_RR_EN for the arbitration-order expectations.
module tb_vga_draw_scheduler;
   import vga_draw_pkg::*;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned X_W     = 8;
   localparam int unsigned Y_W     = 7;
   localparam int unsigned C_W     = 9;
   localparam int unsigned PW      = X_W + Y_W + C_W;

   logic clk = 1'b0;
   logic resetn;
   int   n_cmp = 0, n_bad = 0, plot_cnt = 0, cmpl_cnt = 0;
   logic [PW-1:0] pix_q[$];
   int            cmpl_q[$];

   always #5 clk = ~clk;

   vga_draw_scheduler_if #(.NUM_REQ(NUM_REQ), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) bus ();

   vga_draw_scheduler #(.NUM_REQ(NUM_REQ), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] pix_of(input int idx, input int k, input bit special);
      if (special) return {X_W'(39), Y_W'(39), C_W'(9'h1FF)};
      return {X_W'(k % SCREEN_W), Y_W'((k / SCREEN_W) % SCREEN_H), C_W'((k * 7 + idx * 37) % 512)};
   endfunction

   // Idle engine: valid high with off-screen garbage so a wrong select is visible.
   task automatic park(input int idx);
      bus.eng_valid[idx]             = 1'b1;
      bus.eng_done[idx]              = 1'b0;
      bus.eng_x[idx*X_W +: X_W]      = X_W'(200 + idx);
      bus.eng_y[idx*Y_W +: Y_W]      = Y_W'(121 + idx);
      bus.eng_colour[idx*C_W +: C_W] = C_W'(300 + 50 * idx);
   endtask

   // Scoreboard side: pop on every plot / completion pulse.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (bus.vga_plot) begin
            plot_cnt++;
            if (pix_q.size() == 0) check("plot_extra", 32'(bus.vga_plot), 32'd0);
            else check("pixel", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(pix_q.pop_front()));
         end
         if (bus.cmpl != '0) begin
            cmpl_cnt++;
            if (cmpl_q.size() == 0) check("cmpl_extra", 32'(bus.cmpl), 32'd0);
            else check("cmpl", 32'(bus.cmpl), 32'd1 << cmpl_q.pop_front());
         end
      end
   end

   // One engine pass: wait for grant, stream npix pixels (done with the last one).
   task automatic serve(input int idx, input int npix, input bit keep, input bit stale,
                        input bit special, input int abort_at, output int waited);
      logic [PW-1:0]      p;
      logic [NUM_REQ-1:0] exp_run;
      exp_run      = '1;
      exp_run[idx] = 1'b0;
      waited       = 0;
      if (stale) bus.eng_done[idx] = 1'b1;
      while (bus.eng_run_n[idx] !== 1'b0 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("grant%0d", idx), 32'(bus.eng_run_n), 32'(exp_run));
      if (waited >= 64) return;
      check("busy_arm", 32'(bus.busy), 32'd1);
      bus.eng_valid[idx] = 1'b0;
      @(negedge clk);
      if (stale) begin
         repeat (2) @(negedge clk);
         check("stale_hold", 32'(bus.eng_run_n), 32'(exp_run));
         bus.eng_done[idx] = 1'b0;
      end
      for (int k = 0; k < npix; k++) begin
         if (k == abort_at) begin
            check("pre_rst_plot", 32'(bus.vga_plot), 32'd1);
            #2 resetn = 1'b0;
            #1;
            check("rst_plot", 32'(bus.vga_plot), 32'd0);
            check("rst_run_n", 32'(bus.eng_run_n), 32'hF);
            check("rst_cmpl", 32'(bus.cmpl), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
            pix_q.delete();
            bus.req = '0;
            park(idx);
            @(negedge clk);
            resetn = 1'b1;
            return;
         end
         p = pix_of(idx, k, special);
         {bus.eng_x[idx*X_W +: X_W], bus.eng_y[idx*Y_W +: Y_W], bus.eng_colour[idx*C_W +: C_W]} = p;
         bus.eng_valid[idx] = 1'b1;
         if (k == npix - 1) begin
            bus.eng_done[idx] = 1'b1;
            cmpl_q.push_back(idx);
         end
         pix_q.push_back(p);
         @(negedge clk);
         if (k == 0) begin
            check("latency_plot", 32'(bus.vga_plot), 32'd1);
            if (special) begin
               check("lat_x", 32'(bus.vga_x), 32'd39);
               check("lat_y", 32'(bus.vga_y), 32'd39);
               check("lat_colour", 32'(bus.vga_colour), 32'h1FF);
            end
         end
      end
      check("drain_run_n", 32'(bus.eng_run_n), 32'hF);
      check("drain_busy", 32'(bus.busy), 32'd1);
      park(idx);
      if (!keep) bus.req[idx] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, p0, c0;
      bus.req = '0;
      for (int i = 0; i < NUM_REQ; i++) park(i);
      resetn = 1'b1;
      #1 resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_plot0", 32'(bus.vga_plot), 32'd0);
      check("rst_run_n0", 32'(bus.eng_run_n), 32'hF);
      check("rst_cmpl0", 32'(bus.cmpl), 32'd0);
      check("rst_busy0", 32'(bus.busy), 32'd0);
      check("rst_xyc0", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'd0);

      // Single request, full 3200-pixel pass on engine 2.
      p0 = plot_cnt;
      c0 = cmpl_cnt;
      bus.req = 4'b0100;
      serve(2, 3200, 1'b0, 1'b0, 1'b0, -1, w);
      @(negedge clk);
      check("t1_plots", 32'(plot_cnt - p0), 32'd3200);
      check("t1_cmpls", 32'(cmpl_cnt - c0), 32'd1);
      check("t1_cmpl_low", 32'(bus.cmpl), 32'd0);
      check("t1_run_n", 32'(bus.eng_run_n), 32'hF);
      check("t1_busy", 32'(bus.busy), 32'd0);

      // Two simultaneous requests.
      bus.req = 4'b1010;
`ifdef DRAW_SCHED_RR_EN
      serve(3, 40, 1'b0, 1'b0, 1'b0, -1, w);
      serve(1, 40, 1'b0, 1'b0, 1'b0, -1, w);
`else
      serve(1, 40, 1'b0, 1'b0, 1'b0, -1, w);
      serve(3, 40, 1'b0, 1'b0, 1'b0, -1, w);
`endif
      check("t2_gap", 32'(w), 32'd2);
      @(negedge clk);

      // Stale done on engine 1 entering ARM.
      bus.req = 4'b0010;
      serve(1, 10, 1'b0, 1'b1, 1'b0, -1, w);
      @(negedge clk);

      // Single-pixel pass checking plot latency and values.
      bus.req = 4'b1000;
      serve(3, 1, 1'b0, 1'b0, 1'b1, -1, w);
      @(negedge clk);

      // Async reset at pixel 100, then recovery.
      bus.req = 4'b0001;
      serve(0, 3200, 1'b0, 1'b0, 1'b0, 100, w);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      check("post_rst_plot", 32'(bus.vga_plot), 32'd0);
      bus.req = 4'b0100;
      serve(2, 5, 1'b0, 1'b0, 1'b0, -1, w);
      @(negedge clk);

      // All requests held; restart from reset so round-robin starts at 0.
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      bus.req = 4'b1111;
`ifdef DRAW_SCHED_RR_EN
      serve(0, 8, 1'b1, 1'b0, 1'b0, -1, w);
      serve(1, 8, 1'b1, 1'b0, 1'b0, -1, w);
      check("t3_gap", 32'(w), 32'd2);
      serve(2, 8, 1'b1, 1'b0, 1'b0, -1, w);
      serve(3, 8, 1'b1, 1'b0, 1'b0, -1, w);
      serve(0, 8, 1'b0, 1'b0, 1'b0, -1, w);
      serve(1, 8, 1'b0, 1'b0, 1'b0, -1, w);
      serve(2, 8, 1'b0, 1'b0, 1'b0, -1, w);
      serve(3, 8, 1'b0, 1'b0, 1'b0, -1, w);
`else
      serve(0, 8, 1'b1, 1'b0, 1'b0, -1, w);
      serve(0, 8, 1'b1, 1'b0, 1'b0, -1, w);
      check("t3_gap", 32'(w), 32'd2);
      serve(0, 8, 1'b0, 1'b0, 1'b0, -1, w);
      serve(1, 8, 1'b0, 1'b0, 1'b0, -1, w);
      serve(2, 8, 1'b0, 1'b0, 1'b0, -1, w);
      serve(3, 8, 1'b0, 1'b0, 1'b0, -1, w);
`endif
      repeat (3) @(negedge clk);
      check("end_busy", 32'(bus.busy), 32'd0);
      check("pix_q_empty", 32'(pix_q.size()), 32'd0);
      check("cmpl_q_empty", 32'(cmpl_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
